mem_port_arbiter: RTL and testbench

//  Shares one single-port memory between instruction fetch (IF) and the MEM stage, which is
//  fed from the EX_MEM pipeline register outputs. MEM has fixed priority over IF.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/sat_counter.sv | 30 +++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the single-port memory arbiter.
//   arb_state_e : arbiter FSM states
//   owner_e     : which requester a grant decision selects this cycle
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BUSY_IF  = 3'd1,
    BUSY_MEM = 3'd2,
    IF_DONE  = 3'd3,
    MEM_DONE = 3'd4
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the arbiter performance counters.
//   clk    in  clock, rising edge
//   reset  in  asynchronous, active-high; clears the count
//   inc    in  add one this cycle (ignored once the count is all-ones)
//   clear  in  synchronous clear, wins over inc
//   count  out current count
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CntMax)) begin
      count <= count + CntOne;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and the MEM stage.
// MEM has fixed priority. The memory side is a registered request/ack handshake; the
// pipeline side gets one-cycle done pulses plus stall_if/stall_mem.
//
// Optional build macro: ARB_PERF_CNT_EN enables the saturating perf counters
// conflict_cnt and mem_wait_cnt; without it both ports read 0.
//
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-high reset
//   if_req, if_addr             fetch request (held until if_ready) and address
//   if_ready, if_rdata          fetch-complete pulse and registered instruction
//   mem_read, mem_write         EX_MEM load/store strobes (both set = store)
//   mem_addr, mem_wdata         EX_MEM address and store data
//   mem_done, mem_rdata         MEM-complete pulse and registered load data
//   stall_if, stall_mem         hold PC/IF_ID, hold whole pipeline
//   m_req, m_we, m_addr,        registered memory request, stable while m_req is high
//   m_wdata
//   m_ack, m_rdata              memory completion and read data (valid with m_ack)
//   conflict_cnt                IF requests deferred because MEM won arbitration
//   mem_wait_cnt                cycles with stall_mem high
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic [CNT_W-1:0]  mem_wait_cnt
);

  arb_state_e state;
  owner_e     grant;
  logic       mem_op;

  assign mem_op = mem_read | mem_write;

  // In x_DONE the finishing requester still shows its old request for this cycle,
  // so it is excluded from the grant decision.
  always_comb begin
    grant = OWN_NONE;
    unique case (state)
      IDLE: begin
        if (mem_op) begin
          grant = OWN_MEM;
        end else if (if_req) begin
          grant = OWN_IF;
        end
      end
      MEM_DONE: if (if_req) grant = OWN_IF;
      IF_DONE:  if (mem_op) grant = OWN_MEM;
      default:  grant = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      if_ready  <= 1'b0;
      if_rdata  <= '0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
    end else begin
      if_ready <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        BUSY_IF: begin
          if (m_ack) begin
            state    <= IF_DONE;
            m_req    <= 1'b0;
            if_ready <= 1'b1;
            if_rdata <= m_rdata;
          end
        end
        BUSY_MEM: begin
          if (m_ack) begin
            state    <= MEM_DONE;
            m_req    <= 1'b0;
            mem_done <= 1'b1;
            if (!m_we) begin
              mem_rdata <= m_rdata;
            end
          end
        end
        default: begin
          // IDLE, IF_DONE, MEM_DONE: m_req is low here, so a stray m_ack has no effect.
          unique case (grant)
            OWN_MEM: begin
              state   <= BUSY_MEM;
              m_req   <= 1'b1;
              m_we    <= mem_write;
              m_addr  <= mem_addr;
              m_wdata <= mem_wdata;
            end
            OWN_IF: begin
              state  <= BUSY_IF;
              m_req  <= 1'b1;
              m_we   <= 1'b0;
              m_addr <= if_addr;
            end
            default: state <= IDLE;
          endcase
        end
      endcase
    end
  end

  // Stalls are forced low during reset so every output reads 0 while it is held.
  assign stall_mem = mem_op & ~mem_done & ~reset;
  assign stall_if  = (if_req & ~if_ready & ~reset) | stall_mem;

`ifdef ARB_PERF_CNT_EN
  logic conflict_inc;

  // Only IDLE arbitrates between two fresh requests; x_DONE never defers a new one.
  assign conflict_inc = (state == IDLE) & mem_op & if_req;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_conflict_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (conflict_inc),
    .clear(1'b0),
    .count(conflict_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_mem_wait_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stall_mem),
    .clear(1'b0),
    .count(mem_wait_cnt)
  );
`else
  assign conflict_cnt = '0;
  assign mem_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CntMax = (1 << CNT_W) - 1;
`ifdef ARB_PERF_CNT_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             if_req, if_ready, mem_read, mem_write, mem_done;
  logic             stall_if, stall_mem, m_req, m_we, m_ack;
  logic [31:0]      if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0]      m_addr, m_wdata, m_rdata;
  logic [CNT_W-1:0] conflict_cnt, mem_wait_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_ready    (if_ready),
    .if_rdata    (if_rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_done    (mem_done),
    .mem_rdata   (mem_rdata),
    .stall_if    (stall_if),
    .stall_mem   (stall_mem),
    .m_req       (m_req),
    .m_we        (m_we),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_ack       (m_ack),
    .m_rdata     (m_rdata),
    .conflict_cnt(conflict_cnt),
    .mem_wait_cnt(mem_wait_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Unwritten words read back as a fixed function of their address.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- memory device (environment) ----------------
  logic [31:0] dev_mem[logic [31:0]];
  bit          dev_en;
  int          dev_delay;  // fixed wait cycles, or -1 for random 0..3
  int          dev_ctr, dev_lim;
  bit          dev_busy;

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
  endfunction

  initial begin
    m_ack    = 1'b0;
    m_rdata  = '0;
    dev_busy = 1'b0;
    dev_ctr  = 0;
    dev_lim  = 0;
    forever begin
      @(negedge clk);
      if (!dev_en) continue;
      if (reset || !m_req) begin
        m_ack    = 1'b0;
        dev_busy = 1'b0;
        m_rdata  = $urandom;
      end else begin
        if (!dev_busy) begin
          dev_busy = 1'b1;
          dev_ctr  = 0;
          dev_lim  = (dev_delay < 0) ? int'($urandom_range(0, 3)) : dev_delay;
        end
        if (dev_ctr == dev_lim) begin
          m_ack    = 1'b1;
          dev_busy = 1'b0;
          if (m_we) begin
            dev_mem[m_addr] = m_wdata;
            m_rdata = $urandom;
          end else begin
            m_rdata = dev_rd(m_addr);
          end
        end else begin
          m_ack   = 1'b0;
          m_rdata = $urandom;
          dev_ctr++;
        end
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct packed {
    logic        is_read;
    logic [31:0] data;
  } exp_t;

  logic [31:0] ref_mem[logic [31:0]];
  exp_t        mem_q[$];
  logic [31:0] if_q[$];
  bit          mon_en;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Monitor: stall relations, bus stability, wait counter, and scoreboard pops.
  bit          p_req, p_ack, p_we, have_rd, es_mem, es_if;
  logic [31:0] p_addr, p_wdata, last_rd;
  int unsigned wait_model;
  exp_t        e;

  initial begin
    p_req = 0; p_ack = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    have_rd = 0; last_rd = '0; wait_model = 0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        wait_model = 0;
        p_req      = 0;
        continue;
      end
      es_mem = (mem_read | mem_write) & ~mem_done;
      es_if  = (if_req & ~if_ready) | es_mem;
      chk("stall_mem", 64'(stall_mem), 64'(es_mem));
      chk("stall_if", 64'(stall_if), 64'(es_if));
      chk("mem_wait_cnt", 64'(mem_wait_cnt), PerfOn ? 64'(wait_model) : 64'd0);
      if (es_mem && wait_model < CntMax) wait_model++;
      if (p_req && !p_ack && m_req) begin
        chk("m_bus_stable", {m_we, m_addr}, {p_we, p_addr});
        if (p_we) chk("m_wdata_stable", 64'(m_wdata), 64'(p_wdata));
      end
      if (mon_en && mem_done) begin
        chk("mem_done_expected", 64'(mem_q.size() > 0), 64'd1);
        if (mem_q.size() > 0) begin
          e = mem_q.pop_front();
          if (e.is_read) begin
            chk("mem_rdata", 64'(mem_rdata), 64'(e.data));
            last_rd = e.data;
            have_rd = 1;
          end else if (have_rd) begin
            chk("mem_rdata_hold", 64'(mem_rdata), 64'(last_rd));
          end
        end
      end
      if (mon_en && if_ready) begin
        chk("if_ready_expected", 64'(if_q.size() > 0), 64'd1);
        if (if_q.size() > 0) chk("if_rdata", 64'(if_rdata), 64'(if_q.pop_front()));
      end
      p_req = m_req; p_ack = m_ack; p_we = m_we; p_addr = m_addr; p_wdata = m_wdata;
    end
  end

  // ---------------- random pipeline drivers ----------------
  task automatic run_mem(input int n);
    int          op, c;
    logic [31:0] a, d;
    exp_t        x;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      op = int'($urandom_range(0, 2));  // 0 load, 1 store, 2 both (store)
      a  = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      d  = $urandom;
      mem_read  = (op != 1);
      mem_write = (op != 0);
      mem_addr  = a;
      mem_wdata = d;
      if (op != 0) begin
        ref_mem[a] = d;
        x.is_read  = 1'b0;
        x.data     = d;
      end else begin
        x.is_read = 1'b1;
        x.data    = ref_rd(a);
      end
      mem_q.push_back(x);
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!mem_done && c < 200);
      if (c >= 200) chk("mem_done_timeout", 64'(mem_done), 64'd1);
      @(posedge clk); #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_if(input int n);
    int          c;
    logic [31:0] a;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      a       = 32'h2000 + 32'(4 * $urandom_range(0, 1023));
      if_req  = 1'b1;
      if_addr = a;
      if_q.push_back(ref_rd(a));
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!if_ready && c < 200);
      if (c >= 200) chk("if_ready_timeout", 64'(if_ready), 64'd1);
      @(posedge clk); #1;
      if_req = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {m_req, m_we, if_ready, mem_done, stall_if, stall_mem,
                         conflict_cnt, mem_wait_cnt}, 64'd0);
    chk({tag, "_bus"}, {m_addr, m_wdata}, 64'd0);
    chk({tag, "_data"}, {if_rdata, mem_rdata}, 64'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // ---------------- directed tests, then random traffic ----------------
  int cnt;

  initial begin
    if_req = 0; if_addr = '0; mem_read = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0;
    dev_en = 1; dev_delay = 0; mon_en = 0;
    dev_mem[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    next_cycle();
    reset = 1'b0;

    // Zero-wait load.
    next_cycle();
    mem_read = 1; mem_addr = 32'h100;
    @(negedge clk);
    chk("ld_c0", {stall_mem, m_req}, 2'b10);
    @(negedge clk);
    chk("ld_c1_bus", {m_req, m_we, m_addr}, {1'b1, 1'b0, 32'h100});
    chk("ld_c1", {mem_done, stall_mem}, 2'b01);
    @(negedge clk);
    chk("ld_c2", {mem_done, stall_mem}, 2'b10);
    chk("ld_rdata", 64'(mem_rdata), 64'hDEAD_BEEF);
    next_cycle();
    mem_read = 0;

    // Same-cycle conflict: MEM store first, IF granted from MEM_DONE.
    next_cycle();
    if_req = 1; if_addr = 32'h2040;
    mem_write = 1; mem_addr = 32'h40; mem_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("cf_c0", {stall_if, stall_mem, m_req}, 3'b110);
    @(negedge clk);
    chk("cf_c1_bus", {m_req, m_we, m_addr}, {1'b1, 1'b1, 32'h40});
    chk("cf_c1_wdata", 64'(m_wdata), 64'h1234_5678);
    @(negedge clk);
    chk("cf_c2", {mem_done, if_ready, stall_if, stall_mem}, 4'b1010);
    next_cycle();
    mem_write = 0;
    @(negedge clk);
    chk("cf_c3_bus", {m_req, m_we, m_addr}, {1'b1, 1'b0, 32'h2040});
    @(negedge clk);
    chk("cf_c4", {if_ready, stall_if}, 2'b10);
    chk("cf_if_rdata", 64'(if_rdata), 64'(init_word(32'h2040)));
    chk("cf_stored", 64'(dev_rd(32'h40)), 64'h1234_5678);
    chk("cf_conflict_cnt", 64'(conflict_cnt), PerfOn ? 64'd1 : 64'd0);
    next_cycle();
    if_req = 0;

    // Fetch with three wait states.
    dev_delay = 3;
    next_cycle();
    if_req = 1; if_addr = 32'h2100;
    @(negedge clk);
    chk("ws_c0", {stall_if, m_req}, 2'b10);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("ws_c%0d_bus", c), {m_req, m_addr}, {1'b1, 32'h2100});
      chk($sformatf("ws_c%0d", c), {if_ready, stall_if}, 2'b01);
    end
    @(negedge clk);
    chk("ws_c5", {if_ready, stall_if, m_req}, 3'b100);
    chk("ws_if_rdata", 64'(if_rdata), 64'(init_word(32'h2100)));
    next_cycle();
    if_req = 0;
    dev_delay = 0;

    // Spurious ack while idle; also confirms the earlier store left mem_rdata alone.
    dev_en = 0;
    next_cycle();
    m_ack = 1; m_rdata = 32'hBAD0_BAD0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("sp_c%0d", c), {m_req, if_ready, mem_done}, 3'b000);
      chk($sformatf("sp_c%0d_data", c), {if_rdata, mem_rdata},
          {init_word(32'h2100), 32'hDEAD_BEEF});
    end
    next_cycle();
    m_ack = 0;
    dev_en = 1;

    // Reset in BUSY_MEM.
    dev_delay = 5;
    next_cycle();
    mem_read = 1; mem_addr = 32'h100;
    next_cycle();
    @(negedge clk);
    chk("rs_busy", 64'(m_req), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("rs_mid");
    next_cycle();
    mem_read = 0;
    next_cycle();
    reset = 1'b0;
    dev_delay = 0;
    next_cycle();
    mem_read = 1; mem_addr = 32'h100;
    repeat (3) @(negedge clk);
    chk("rs_reload", {mem_done, mem_rdata}, {1'b1, 32'hDEAD_BEEF});
    next_cycle();
    mem_read = 0;

    // Long stall saturates mem_wait_cnt.
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    dev_delay = 30;
    next_cycle();
    mem_read = 1; mem_addr = 32'h100;
    repeat (16) @(negedge clk);
    chk("sat_c15", 64'(mem_wait_cnt), PerfOn ? 64'd15 : 64'd0);
    repeat (5) @(negedge clk);
    chk("sat_c20", 64'(mem_wait_cnt), PerfOn ? 64'd15 : 64'd0);
    cnt = 0;
    while (!mem_done && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("sat_done", 64'(mem_done), 64'd1);
    next_cycle();
    mem_read = 0;
    dev_delay = -1;

    // Random concurrent traffic.
    next_cycle();
    mon_en = 1;
    fork
      run_mem(60);
      run_if(60);
    join
    repeat (10) @(negedge clk);
    chk("mem_q_drained", 64'(mem_q.size()), 64'd0);
    chk("if_q_drained", 64'(if_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors + 0);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
